// File: rtl/layer_output_serializer.sv
// Layer output serializer: snapshots a bank of signed neuron accumulators on
// a capture strobe, then streams them one per accepted transfer as unsigned
// saturated activations (ReLU, fixed-point rescale, clamp) with a
// valid/ready handshake. A capture that arrives mid-stream is dropped and
// raises a sticky overrun flag. The exception is a capture on the final
// transfer, which is accepted back-to-back.
module layer_output_serializer #(
    parameter int NUM        = 28,
    parameter int ACC_W      = 18,
    parameter int OUT_W      = 8,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 capture,
    input  logic [NUM*ACC_W-1:0] mac_in,
    input  logic                 out_ready,
    input  logic                 ovr_clr,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    output logic [4:0]           out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [4:0]       LAST_IDX = 5'(NUM - 1);
    localparam logic [ACC_W-1:0] MAX_ACT  = ACC_W'((2 ** OUT_W) - 1);

    // Negative -> 0; otherwise drop the fractional bits and clamp to the
    // largest unsigned output code.
    function automatic logic [OUT_W-1:0] activate(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] scaled;
        scaled = v >> FRAC_SHIFT;
        if (v[ACC_W-1])
            activate = '0;
        else if (scaled > MAX_ACT)
            activate = '1;
        else
            activate = scaled[OUT_W-1:0];
    endfunction

    state_t           state;
    logic [ACC_W-1:0] shadow [NUM];
    logic [4:0]       next_index;
    logic             xfer;
    logic             final_xfer;
    logic             accept;

    assign xfer       = out_valid & out_ready;
    assign final_xfer = xfer && (out_index == LAST_IDX);
    // A new snapshot is taken when idle, or when it lands exactly on the
    // last handshake of the current stream (back-to-back layers).
    assign accept     = capture && ((state == IDLE) || final_xfer);
    assign next_index = out_index + 5'd1;
    assign busy       = (state == STREAM);

    // Stream control, shadow bank, registered outputs and sticky overrun.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so that all of them update from
        // the same pre-edge values, independent of statement order.
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
            // NOTE: the shadow bank is cleared on reset so that a stale
            // snapshot can never reappear after a reset.
            for (int k = 0; k < NUM; k++) shadow[k] <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < NUM; k++) shadow[k] <= mac_in[k*ACC_W +: ACC_W];
                state     <= STREAM;
                out_valid <= 1'b1;
                out_index <= '0;
                out_data  <= activate(mac_in[0 +: ACC_W]);
                out_last  <= (LAST_IDX == 5'd0);
            end else if (final_xfer) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (xfer) begin
                out_index <= next_index;
                out_data  <= activate(shadow[next_index]);
                out_last  <= (next_index == LAST_IDX);
            end

            if (capture && (state == STREAM) && !final_xfer)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Testbench for layer_output_serializer. The reference model describes the
// expected output as a queue of (index, activation) items still owed from the
// current snapshot. Activations come from plain integer arithmetic.
module tb_layer_output_serializer;

    localparam int NUM        = 28;
    localparam int ACC_W      = 18;
    localparam int OUT_W      = 8;
    localparam int FRAC_SHIFT = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 capture;
    logic                 out_ready;
    logic                 ovr_clr;
    logic [NUM*ACC_W-1:0] mac_in;
    logic [ACC_W-1:0]     mac [NUM];
    logic [OUT_W-1:0]     out_data;
    logic                 out_valid;
    logic [4:0]           out_index;
    logic                 out_last;
    logic                 busy;
    logic                 overrun;

    layer_output_serializer #(
        .NUM(NUM), .ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .capture(capture), .mac_in(mac_in),
        .out_ready(out_ready), .ovr_clr(ovr_clr), .out_data(out_data),
        .out_valid(out_valid), .out_index(out_index), .out_last(out_last),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        mac_in = '0;
        for (int k = 0; k < NUM; k++) mac_in[k*ACC_W +: ACC_W] = mac[k];
    end

    typedef struct {
        int idx;
        int data;
    } item_t;

    item_t exp_q[$];
    bit    exp_ovr;
    bit    fresh_reset;
    int    vectors     = 0;
    int    miscompares = 0;

    // Accumulator as a signed integer; negative -> 0, else floor divide by
    // 2^FRAC_SHIFT and clamp to 2^OUT_W - 1.
    function automatic int act(input logic [ACC_W-1:0] v);
        int s;
        s = int'(signed'(v));
        if (s < 0) return 0;
        s = s / (1 << FRAC_SHIFT);
        if (s > (1 << OUT_W) - 1) return (1 << OUT_W) - 1;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("busy", 32'(busy), 32'(exp_q.size() > 0));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        if (exp_q.size() > 0) begin
            check("out_index", 32'(out_index), exp_q[0].idx);
            check("out_data", 32'(out_data), exp_q[0].data);
            check("out_last", 32'(out_last), 32'(exp_q[0].idx == NUM - 1));
        end else begin
            check("out_last_idle", 32'(out_last), 0);
            if (fresh_reset) begin
                check("out_data_rst", 32'(out_data), 0);
                check("out_index_rst", 32'(out_index), 0);
            end
        end
    endtask

    // One clock: drive inputs, compare outputs settled from the previous
    // edge, then advance the model by the same inputs.
    task automatic cycle(input bit cap, input bit rdy, input bit clr, input bit rst);
        bit fire, fin, take, ovr_set;
        capture = cap; out_ready = rdy; ovr_clr = clr; reset = rst;
        #1;
        check_outputs();
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            exp_ovr     = 1'b0;
            fresh_reset = 1'b1;
        end else begin
            fire    = (exp_q.size() > 0) && rdy;
            fin     = fire && (exp_q.size() == 1);
            take    = cap && ((exp_q.size() == 0) || fin);
            ovr_set = cap && (exp_q.size() > 0) && !fin;
            if (fire) void'(exp_q.pop_front());
            if (take) begin
                exp_q.delete();
                for (int k = 0; k < NUM; k++) exp_q.push_back('{k, act(mac[k])});
                fresh_reset = 1'b0;
            end
            if (ovr_set) exp_ovr = 1'b1;
            else if (clr) exp_ovr = 1'b0;
        end
        @(negedge clk);
    endtask

    // Stream with ready high until the given index is presented (bounded).
    task automatic run_to(input int idx);
        for (int i = 0; i < 64 && !(exp_q.size() > 0 && exp_q[0].idx == idx); i++)
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("seek_index", 32'(exp_q.size() > 0 && exp_q[0].idx == idx), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++)
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("drained_busy", 32'(busy), 0);
    endtask

    task automatic rand_mac();
        for (int k = 0; k < NUM; k++) begin
            case ($urandom_range(0, 3))
                0:       mac[k] = ACC_W'($urandom_range(0, 65535));
                1:       mac[k] = ACC_W'($urandom_range(0, 2047));
                default: mac[k] = ACC_W'($urandom);
            endcase
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int xfers;

        for (int k = 0; k < NUM; k++) mac[k] = '0;
        capture = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0; reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_ovr     = 1'b0;
        fresh_reset = 1'b1;

        // Reset state; capture asserted together with reset is ignored.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Three distinct neurons, rest zero, continuous ready.
        mac[0] = 18'h00500; mac[1] = 18'h3FF00; mac[2] = 18'h1FFFF;
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("n0_data", 32'(out_data), 5);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("n1_data", 32'(out_data), 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("n2_data", 32'(out_data), 255);
        drain();

        // Ready toggling 1/0: 28 transfers in 56 cycles, held during stalls.
        rand_mac();
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        xfers = 0;
        for (int i = 0; i < 2 * NUM; i++) begin
            if (out_valid && (i % 2 == 0)) xfers++;
            cycle(1'b0, (i % 2 == 0), 1'b0, 1'b1);
        end
        check("toggle_xfers", xfers, NUM);
        check("toggle_done", 32'(out_valid), 0);

        // Capture mid-stream: dropped, overrun set; clear; set beats clear.
        rand_mac();
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        run_to(10);
        rand_mac();
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("ovr_set", 32'(overrun), 1);
        run_to(20);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("ovr_clr", 32'(overrun), 0);
        run_to(24);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("ovr_set_wins", 32'(overrun), 1);
        drain();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);

        // Capture on the final transfer: back-to-back with no bubble.
        rand_mac();
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        run_to(NUM - 1);
        for (int k = 0; k < NUM; k++) mac[k] = 18'h00A00;
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("b2b_valid", 32'(out_valid), 1);
        check("b2b_index", 32'(out_index), 0);
        check("b2b_data", 32'(out_data), 10);
        check("b2b_no_ovr", 32'(overrun), 0);
        drain();

        // Reset mid-stream abandons it; capture after release restarts at 0.
        rand_mac();
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        run_to(3);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        run_to(5);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        rand_mac();
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("restart_index", 32'(out_index), 0);
        drain();

        // Truncation and saturation corners.
        rand_mac();
        mac[0] = 18'h0FF80; mac[1] = 18'h000FF; mac[2] = 18'h20000; mac[3] = 18'h10000;
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("trunc_255", 32'(out_data), 255);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("frac_only", 32'(out_data), 0);
        // Inputs changing mid-stream must not alter the snapshot.
        rand_mac();
        drain();

        // Random traffic: ready, captures, clears, rare resets, input churn.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) rand_mac();
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 199) != 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layer_output_serializer.md
LAYER_OUTPUT_SERIALIZER -- requirements
Module: layer_output_serializer

Interface
REQ-001 SHALL have parameter NUM, default 28, number of neuron accumulators consumed.
REQ-002 SHALL have parameter ACC_W, default 18, accumulator width, signed two's complement.
REQ-003 SHALL have parameter OUT_W, default 8, output activation width, unsigned.
REQ-004 SHALL have parameter FRAC_SHIFT, default 8, right-shift applied before saturation.
REQ-005 SHALL have a single clock and a synchronous, active-low reset.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous active-low reset.
REQ-008 SHALL have port capture  input  1  one-cycle strobe: accumulators final, snapshot them.
REQ-009 SHALL have port mac_in  input  NUM*ACC_W  flattened accumulators; neuron k (0-based) at bits [k*ACC_W +: ACC_W].
REQ-010 SHALL have port out_ready  input  1  downstream (next-layer loader) accepts out_data this cycle.
REQ-011 SHALL have port ovr_clr  input  1  clears overrun flag.
REQ-012 SHALL have port out_data  output  OUT_W  activated value of current neuron.
REQ-013 SHALL have port out_valid  output  1  out_data/out_index valid.
REQ-014 SHALL have port out_index  output  5  neuron index 0..NUM-1 of out_data.
REQ-015 SHALL have port out_last  output  1  high with out_valid when out_index = NUM-1.
REQ-016 SHALL have port busy  output  1  high while in STREAM state.
REQ-017 SHALL have port overrun  output  1  sticky: capture arrived while streaming.

Function
REQ-018 SHALL implement two states, IDLE and STREAM; busy = (state == STREAM).
REQ-019 SHALL, in IDLE with capture=1, copy all NUM accumulators into a shadow register bank, set out_index=0, enter STREAM.
REQ-020 SHALL assert out_valid one cycle after the capture edge (latency 1), presenting neuron 0.
REQ-021 SHALL hold out_data, out_index, out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on out_valid & out_ready with out_index < NUM-1, increment out_index and present the next neuron the following cycle, no bubble.
REQ-023 SHALL, on out_valid & out_ready with out_index = NUM-1, return to IDLE and deassert out_valid next cycle, unless REQ-025 applies.
REQ-024 SHALL compute activation: if shadow value negative, 0; else v >>> FRAC_SHIFT, saturated to 2^OUT_W-1 if larger; out_data driven from a register.
REQ-025 SHALL, when capture coincides with the final transfer (REQ-023), accept the capture: reload shadow, out_index=0, stay in STREAM, out_valid stays high.
REQ-026 SHALL, on capture in STREAM other than REQ-025, ignore the data, keep streaming the old snapshot, set overrun=1.
REQ-027 SHALL clear overrun when ovr_clr=1; simultaneous set and clear: set wins.
REQ-028 SHALL not change shadow bank contents except on an accepted capture; mac_in changes mid-stream have no effect.

Reset
REQ-029 SHALL, while reset=0 at a clock edge, force state=IDLE, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, overrun=0, shadow bank=0.
REQ-030 SHALL, on reset mid-stream, abandon the stream; no further out_valid until a new capture after reset release.
REQ-031 SHALL ignore capture in the same cycle as reset=0.

Verification
REQ-032 SHALL verify: neuron0=0x00500, neuron1=0x3FF00, neuron2=0x1FFFF, rest 0, capture, out_ready=1 -> out_data 5,0,255,0..., indices 0..27 on 28 consecutive cycles, out_last only at 27, busy low after.
REQ-033 SHALL verify: out_ready toggled 1/0 each cycle -> 28 transfers over 56 cycles, values held during stalls, none dropped or duplicated.
REQ-034 SHALL verify: capture at index 10 -> overrun=1, stream continues old snapshot; ovr_clr -> overrun=0 next cycle.
REQ-035 SHALL verify: second capture (all neurons 0x00A00) in same cycle as index-27 transfer -> next cycle out_valid=1, out_index=0, out_data=10.
REQ-036 SHALL verify: reset=0 at index 5 -> next cycle all outputs at reset values; capture after release restarts at index 0.
REQ-037 SHALL verify: neuron value 0x0FF80 (65408) -> out_data 255 (255.5 truncated); 0x000FF -> 0.
